// File: rtl/heartbeat_monitor.sv
// -----------------------------------------------------------------------------
// heartbeat_monitor
//   Watches the 1-cycle heartbeat pulse from the heartbeat counter and checks
//   its cadence. It measures the interval between rising edges of `beat` and
//   locks after LOCK_COUNT consecutive in-window intervals. Once locked, an
//   early, late or missing beat is a fault. A fault pulses fault_pulse for one
//   cycle, sets the sticky alarm, and bumps a saturating fault_count.
//   The monitor runs in the same clock domain as the heartbeat source.
//
// Ports
//   clk          in   1   clock
//   nreset       in   1   asynchronous active-low reset
//   enable       in   1   1 = monitor running, 0 = idle
//   beat         in   1   heartbeat input; each rising edge is one beat
//   clear        in   1   1-cycle strobe that clears alarm and fault_count
//   locked       out  1   cadence locked
//   alarm        out  1   sticky fault flag
//   fault_pulse  out  1   1-cycle pulse for each detected fault
//   period       out  W   last measured beat interval, in cycles
//   fault_count  out  FW  faults since reset/clear, saturating
// -----------------------------------------------------------------------------
module heartbeat_monitor #(
  parameter int W          = 16,
  parameter int MIN_PERIOD = 254,
  parameter int MAX_PERIOD = 258,
  parameter int LOCK_COUNT = 4,
  parameter int FW         = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          enable,
  input  logic          beat,
  input  logic          clear,
  output logic          locked,
  output logic          alarm,
  output logic          fault_pulse,
  output logic [W-1:0]  period,
  output logic [FW-1:0] fault_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [W-1:0]  MIN_P     = W'(MIN_PERIOD);
  localparam logic [W-1:0]  MAX_P     = W'(MAX_PERIOD);
  localparam logic [W-1:0]  CNT_ONE   = W'(1);
  localparam logic [W-1:0]  CNT_SAT   = '1;
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_COUNT);
  localparam logic [FW-1:0] FC_SAT    = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TRACK,
    LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic          beat_dly_q;
  logic [W-1:0]  period_q, period_d;
  logic          locked_q, locked_d;
  logic          alarm_q, alarm_d;
  logic          fault_pulse_q, fault_pulse_d;
  logic [FW-1:0] fault_count_q, fault_count_d;

  logic          beat_edge;
  logic          in_win;
  logic          timeout;
  logic          fault;
  logic [W-1:0]  cnt_next;
  logic [GW-1:0] good_inc;

  // A held-high beat produces only one edge.
  assign beat_edge = beat & ~beat_dly_q;
  assign in_win    = (cnt_q >= MIN_P) && (cnt_q <= MAX_P);
  // Fire on the last acceptable cycle. A beat that arrives one cycle later is
  // therefore reported as missing, not as late.
  assign timeout   = !beat_edge && (cnt_q == MAX_P);
  assign cnt_next  = beat_edge ? CNT_ONE
                   : (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
  assign good_inc  = good_q + GW'(1);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    period_d = period_q;
    fault    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        good_d = '0;
        if (enable) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        cnt_d = cnt_next;
        if (beat_edge) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        cnt_d = cnt_next;
        if (beat_edge) begin
          period_d = cnt_q;
          if (in_win) begin
            good_d = good_inc;
            if (good_inc == GOOD_LOCK) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      LOCKED: begin
        cnt_d = cnt_next;
        if (beat_edge) begin
          period_d = cnt_q;
          if (!in_win) begin
            fault   = 1'b1;
            state_d = TRACK;
            good_d  = '0;
          end
        end else if (timeout) begin
          fault   = 1'b1;
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disabling overrides everything. A fault found in the same cycle is
    // dropped, and the last measured period is kept.
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      good_d   = '0;
      period_d = period_q;
      fault    = 1'b0;
    end

    // Register the next state so that locked follows the deciding cycle
    // with one cycle of latency, not two.
    locked_d      = (state_d == LOCKED);
    fault_pulse_d = fault;

    // A fault takes priority over clear, so nothing is lost when both
    // happen in the same cycle.
    alarm_d       = fault ? 1'b1 : (clear ? 1'b0 : alarm_q);
    if (clear) begin
      fault_count_d = fault ? FW'(1) : '0;
    end else if (fault && (fault_count_q != FC_SAT)) begin
      fault_count_d = fault_count_q + FW'(1);
    end else begin
      fault_count_d = fault_count_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      good_q        <= '0;
      beat_dly_q    <= 1'b0;
      period_q      <= '0;
      locked_q      <= 1'b0;
      alarm_q       <= 1'b0;
      fault_pulse_q <= 1'b0;
      fault_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      good_q        <= good_d;
      beat_dly_q    <= beat;
      period_q      <= period_d;
      locked_q      <= locked_d;
      alarm_q       <= alarm_d;
      fault_pulse_q <= fault_pulse_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign locked      = locked_q;
  assign alarm       = alarm_q;
  assign fault_pulse = fault_pulse_q;
  assign period      = period_q;
  assign fault_count = fault_count_q;

endmodule
